zeroriscy_wb_arbiter: RTL



---
 rtl/zeroriscy_wb_pkg.sv | 10 +
 rtl/zeroriscy_wb_addr_fifo.sv | 51 +++++
 rtl/zeroriscy_wb_arbiter.sv | 93 +++++++++
 3 files changed

// File: rtl/zeroriscy_wb_pkg.sv
// zeroriscy_wb_pkg: shared types and helpers for the writeback arbiter
package zeroriscy_wb_pkg;
  localparam int REG_ADDR_W = 5;
  typedef enum logic [1:0] {SRC_NONE, SRC_LSU, SRC_SKID, SRC_EX} src_e;
  function automatic logic reg_match(input logic [REG_ADDR_W-1:0] a, input logic [REG_ADDR_W-1:0] b, input logic rv32e);
    logic [REG_ADDR_W-1:0] m;
    m = rv32e ? 5'h0f : 5'h1f;
    return ((a & m) == (b & m)) && ((a & m) != '0);
  endfunction
endpackage

// File: rtl/zeroriscy_wb_addr_fifo.sv
// zeroriscy_wb_addr_fifo: in-order destination FIFO for outstanding loads
module zeroriscy_wb_addr_fifo
  import zeroriscy_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 push_i,
  input  logic [REG_ADDR_W-1:0]                push_addr_i,
  input  logic                                 pop_i,
  output logic                                 full_o,
  output logic                                 empty_o,
  output logic [REG_ADDR_W-1:0]                head_o,
  output logic [DEPTH-1:0][REG_ADDR_W-1:0]     entries_o,
  output logic [DEPTH-1:0]                     valid_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_count;
  logic w_push, w_pop;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  assign full_o  = r_count == CW'(DEPTH);
  assign empty_o = r_count == '0;
  assign head_o  = entries_o[r_rptr];
  assign w_pop   = pop_i && !empty_o;
  assign w_push  = push_i && (!full_o || w_pop);
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      valid_o   <= '0;
      entries_o <= '0;
    end else begin
      if (w_pop) begin
        valid_o[r_rptr] <= 1'b0;
        r_rptr          <= nxt(r_rptr);
      end
      if (w_push) begin
        entries_o[r_wptr] <= push_addr_i;
        valid_o[r_wptr]   <= 1'b1;
        r_wptr            <= nxt(r_wptr);
      end
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end
endmodule

// File: rtl/zeroriscy_wb_arbiter.sv
// zeroriscy_wb_arbiter: merges EX results and load returns onto the register file write port
module zeroriscy_wb_arbiter
  import zeroriscy_wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int LOAD_DEPTH = 2,
  parameter bit RV32E      = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_wb_valid_i,
  input  logic [4:0]            ex_wb_addr_i,
  input  logic [DATA_WIDTH-1:0] ex_wb_data_i,
  output logic                  ex_wb_ready_o,
  input  logic                  lsu_issue_i,
  input  logic [4:0]            lsu_issue_addr_i,
  output logic                  lsu_issue_ready_o,
  input  logic                  lsu_rvalid_i,
  input  logic [DATA_WIDTH-1:0] lsu_rdata_i,
  input  logic                  lsu_err_i,
  input  logic [4:0]            raddr_a_i,
  input  logic [4:0]            raddr_b_i,
  input  logic [4:0]            id_waddr_i,
  input  logic                  id_waddr_en_i,
  output logic [4:0]            waddr_a_o,
  output logic [DATA_WIDTH-1:0] wdata_a_o,
  output logic                  we_a_o,
  output logic                  stall_o
);
  logic                                  w_full, w_empty, w_lsu, w_ex_acc, w_we;
  logic [REG_ADDR_W-1:0]                 w_head, w_addr;
  logic [DATA_WIDTH-1:0]                 w_data;
  logic [LOAD_DEPTH-1:0][REG_ADDR_W-1:0] w_ent;
  logic [LOAD_DEPTH-1:0]                 w_vld;
  logic [2:0][REG_ADDR_W-1:0]            w_id;
  src_e                                  w_src;
  logic                                  r_skid_v;
  logic [REG_ADDR_W-1:0]                 r_skid_addr;
  logic [DATA_WIDTH-1:0]                 r_skid_data;
  zeroriscy_wb_addr_fifo #(.DEPTH(LOAD_DEPTH)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (lsu_issue_i && lsu_issue_ready_o),
    .push_addr_i (lsu_issue_addr_i),
    .pop_i       (w_lsu),
    .full_o      (w_full),
    .empty_o     (w_empty),
    .head_o      (w_head),
    .entries_o   (w_ent),
    .valid_o     (w_vld)
  );
  assign ex_wb_ready_o     = !r_skid_v;
  assign lsu_issue_ready_o = !w_full || lsu_rvalid_i;
  assign w_lsu             = lsu_rvalid_i && !w_empty;
  assign w_ex_acc          = ex_wb_valid_i && ex_wb_ready_o;
  assign w_src  = w_lsu ? SRC_LSU : r_skid_v ? SRC_SKID : w_ex_acc ? SRC_EX : SRC_NONE;
  assign w_addr = w_src == SRC_LSU ? w_head : w_src == SRC_SKID ? r_skid_addr : ex_wb_addr_i;
  assign w_data = w_src == SRC_LSU ? lsu_rdata_i : w_src == SRC_SKID ? r_skid_data : ex_wb_data_i;
  assign w_we   = w_src != SRC_NONE && !(w_src == SRC_LSU && lsu_err_i) && reg_match(w_addr, w_addr, RV32E);
  assign w_id   = {id_waddr_en_i ? id_waddr_i : 5'd0, raddr_b_i, raddr_a_i};
  // the write port counts as pending: the file only updates at the end of that cycle
  always_comb begin
    stall_o = 1'b0;
    for (int k = 0; k < 3; k++) begin
      stall_o = stall_o || (r_skid_v && reg_match(w_id[k], r_skid_addr, RV32E)) || (we_a_o && reg_match(w_id[k], waddr_a_o, RV32E));
      for (int e = 0; e < LOAD_DEPTH; e++) stall_o = stall_o || (w_vld[e] && reg_match(w_id[k], w_ent[e], RV32E));
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_skid_v    <= 1'b0;
      r_skid_addr <= '0;
      r_skid_data <= '0;
      we_a_o      <= 1'b0;
      waddr_a_o   <= '0;
      wdata_a_o   <= '0;
    end else begin
      we_a_o <= w_we;
      if (w_src != SRC_NONE) begin
        waddr_a_o <= w_addr;
        wdata_a_o <= w_data;
      end
      if (w_lsu && w_ex_acc) begin
        r_skid_v    <= 1'b1;
        r_skid_addr <= ex_wb_addr_i;
        r_skid_data <= ex_wb_data_i;
      end else if (w_src == SRC_SKID) begin
        r_skid_v <= 1'b0;
      end
    end
  end
  assert property (@(posedge clk) disable iff (!rst_n) lsu_issue_i |-> lsu_issue_ready_o);
endmodule
